multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle control unit that drives the control inputs of the RV32I single-issue datapath.
- Decodes the current instruction word and sequences each instruction through IF/ID/EX/MEM/WB.
- Generates loadPC, PCSrc, ALUSrc, ALUCtrl, RegWrite and MemToReg for the datapath, and MemRead/MemWrite for data memory, with a ready handshake.
- Also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- WAIT_LIMIT, 16, maximum cycles spent in MEM waiting for dmem_ready before a timeout error is raised; must be ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  current instruction; stable from IF until the PC update edge.
- Zero  input  1  ALU zero flag from the datapath.
- dmem_ready  input  1  data memory has completed the current read/write.
- loadPC  output  1  PC update enable.
- PCSrc  output  1  1 = branch target, 0 = PC+4.
- ALUSrc  output  1  1 = immediate operand, 0 = register operand.
- ALUCtrl  output  4  ALU operation.
- RegWrite  output  1  register file write enable.
- MemToReg  output  1  1 = write back load data.
- MemRead  output  1  data memory read strobe.
- MemWrite  output  1  data memory write strobe.
- illegal  output  1  one-cycle pulse on an unsupported instruction.
- mem_timeout  output  1  sticky error flag, cleared only by rst.
- instret  output  32  retired-instruction count.
- state  output  3  current FSM state, for debug.

Behaviour:
- **State encoding:** IF=0, ID=1, EX=2, MEM=3, WB=4; other encodings go to IF on the next clock.
- **Reset:** while rst=1 every output is forced to 0 combinationally. On the reset edge state←IF, instret←0, mem_timeout←0, wait counter←0. Reset mid-instruction abandons it with no register, memory or PC write in the reset cycle.
- **ALUCtrl encoding:** AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- **Supported instructions:**
  - R-type (op 0110011): ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT. funct7[5] selects SUB/SRA.
  - I-ALU (op 0010011): ADDI/ANDI/ORI/XORI/SLTI/SLLI/SRLI/SRAI.
  - LW (op 0000011, funct3 010).
  - SW (op 0100011, funct3 010).
  - BEQ (op 1100011, funct3 000).
  - Everything else is illegal.
- **Output defaults:** outputs are 0 unless listed. Outputs are a combinational function of state, instr, Zero and dmem_ready.
- **IF:** → ID.
- **ID:** → EX.
- **EX, R-type:** ALUSrc=0, ALUCtrl per funct; → WB.
- **EX, I-ALU:** ALUSrc=1, ALUCtrl per funct; → WB.
- **EX, LW/SW:** ALUSrc=1, ALUCtrl=ADD; → MEM.
- **EX, BEQ:** ALUSrc=0, ALUCtrl=SUB, loadPC=1, PCSrc=Zero; → IF; instret+1.
- **EX, illegal:** illegal=1, loadPC=1, PCSrc=0; → IF; instret unchanged.
- **MEM:** ALUSrc=1, ALUCtrl=ADD held. MemRead=1 (LW) or MemWrite=1 (SW) held until dmem_ready=1.
  - SW and dmem_ready: loadPC=1; → IF; instret+1.
  - LW and dmem_ready: → WB.
  - Wait counter increments each MEM cycle with dmem_ready=0. On reaching WAIT_LIMIT: mem_timeout←1, strobes drop, loadPC=1, PCSrc=0, → IF, no retire.
  - Wait counter clears on leaving MEM.
- **WB:** ALUSrc and ALUCtrl held from EX; RegWrite=1; loadPC=1; PCSrc=0; → IF; instret+1.
  - LW: MemToReg=1 and MemRead=1, so memory holds dReadData.
  - The register write and the PC update occur on the same edge.
- **Cycles per instruction:** R/I = 4, BEQ = 3, illegal = 3, SW = 4+waits, LW = 5+waits.
- **Invariants:**
  - loadPC is asserted exactly once per instruction.
  - RegWrite and MemWrite are never both 1.
  - instret wraps 0xFFFFFFFF→0.
- **Simultaneous events:** rst has priority over any transition or strobe. dmem_ready outside MEM is ignored.

Test Plan:
- rst=1 for 2 cycles with instr=0x002081B3 → all outputs 0, state=0, instret=0; after release state goes 0→1→2→4→0.
- ADD x3,x1,x2 (0x002081B3) → EX ALUCtrl=0010, ALUSrc=0; WB RegWrite=1, loadPC=1, PCSrc=0; instret=1. SUB (0x402081B3) → ALUCtrl=0110. ADDI x1,x0,5 (0x00500093) → ALUSrc=1, ALUCtrl=0010.
- LW x5,8(x2) (0x00812283) with dmem_ready low 3 cycles → MemRead=1 for 4 MEM cycles; WB MemToReg=1, RegWrite=1; total 8 cycles, instret+1. SW x5,12(x2) (0x00512623) with immediate ready → MemWrite=1 for 1 cycle, RegWrite never 1, loadPC in MEM.
- BEQ x1,x2,+8 (0x00208463) with Zero=1 → EX loadPC=1, PCSrc=1; with Zero=0 → PCSrc=0; 3 cycles each, no RegWrite.
- instr=0x00000000 → illegal=1 for one cycle in EX, loadPC=1, PCSrc=0, instret unchanged. LW with dmem_ready held 0 → after 16 MEM cycles mem_timeout=1 (sticky), state=IF; cleared only by rst. rst asserted during WB of ADD → RegWrite=0 that cycle, state=IF.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RV32I single-issue datapath.
// Sequences each instruction through IF/ID/EX/MEM/WB, drives the datapath
// and data-memory control strobes, counts retired instructions and flags
// illegal opcodes and data-memory timeouts.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dmem_ready,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Instruction classes
  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_I   = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_SW  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_ILL = 3'd5;

  // The wait counter only has to reach WAIT_LIMIT-1: the cycle after that is the timeout.
  localparam int WCW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  // Classify an instruction word; anything not explicitly supported is illegal.
  function automatic logic [2:0] decode_kind(input logic [31:0] iw);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [2:0] kind;
    op   = iw[6:0];
    f3   = iw[14:12];
    f7   = iw[31:25];
    kind = K_ILL;
    case (op)
      7'b0110011: begin
        if ((f7 == 7'b0000000 && f3 != 3'b011) ||
            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          kind = K_R;
        else
          kind = K_ILL;
      end
      7'b0010011: begin
        case (f3)
          3'b011:  kind = K_ILL;
          3'b001:  kind = (f7 == 7'b0000000) ? K_I : K_ILL;
          3'b101:  kind = (f7 == 7'b0000000 || f7 == 7'b0100000) ? K_I : K_ILL;
          default: kind = K_I;
        endcase
      end
      7'b0000011: kind = (f3 == 3'b010) ? K_LW : K_ILL;
      7'b0100011: kind = (f3 == 3'b010) ? K_SW : K_ILL;
      7'b1100011: kind = (f3 == 3'b000) ? K_BEQ : K_ILL;
      default:    kind = K_ILL;
    endcase
    return kind;
  endfunction

  // ALU operation for an ALU-class funct3; alt selects SUB/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [2:0]     state_r;
  logic [2:0]     next_s;
  logic [WCW-1:0] wait_r;
  logic           timeout_r;
  logic [31:0]    instret_r;
  logic [2:0]     kind_s;
  logic [3:0]     alu_s;
  logic           src_s;
  logic           mem_hit_s;
  logic           retire_s;

  // Decode the instruction into its class and the ALU controls used from EX onward.
  always_comb begin
    kind_s = decode_kind(instr);
    case (kind_s)
      K_R:     begin alu_s = alu_op(instr[14:12], instr[30]); src_s = 1'b0; end
      K_I:     begin alu_s = alu_op(instr[14:12], instr[30] && (instr[14:12] == 3'b101)); src_s = 1'b1; end
      K_LW:    begin alu_s = ALU_ADD; src_s = 1'b1; end
      K_SW:    begin alu_s = ALU_ADD; src_s = 1'b1; end
      K_BEQ:   begin alu_s = ALU_SUB; src_s = 1'b0; end
      default: begin alu_s = ALU_AND; src_s = 1'b0; end
    endcase
  end

  assign mem_hit_s = (state_r == S_MEM) && !dmem_ready && (wait_r == WAIT_LAST);
  assign retire_s  = ((state_r == S_EX) && (kind_s == K_BEQ)) ||
                     ((state_r == S_MEM) && (kind_s == K_SW) && dmem_ready) ||
                     (state_r == S_WB);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IF;
    else     state_r <= next_s;
  end

  // Next-state logic.
  always_comb begin
    next_s = S_IF;
    case (state_r)
      S_IF: next_s = S_ID;
      S_ID: next_s = S_EX;
      S_EX: begin
        case (kind_s)
          K_R, K_I:   next_s = S_WB;
          K_LW, K_SW: next_s = S_MEM;
          default:    next_s = S_IF;
        endcase
      end
      S_MEM: begin
        if (dmem_ready)
          next_s = (kind_s == K_LW) ? S_WB : S_IF;
        else if (wait_r == WAIT_LAST)
          next_s = S_IF;
        else
          next_s = S_MEM;
      end
      S_WB:    next_s = S_IF;
      default: next_s = S_IF;
    endcase
  end

  // Wait counter, sticky timeout flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r    <= '0;
      timeout_r <= 1'b0;
      instret_r <= 32'd0;
    end else begin
      if ((state_r == S_MEM) && !dmem_ready && (wait_r != WAIT_LAST))
        wait_r <= wait_r + WCW'(1);
      else
        wait_r <= '0;
      timeout_r <= timeout_r | mem_hit_s;
      if (retire_s) instret_r <= instret_r + 32'd1;
      else          instret_r <= instret_r;
    end
  end

  // Output decode; reset forces every output low.
  always_comb begin
    loadPC      = 1'b0;
    PCSrc       = 1'b0;
    ALUSrc      = 1'b0;
    ALUCtrl     = 4'b0000;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    instret     = 32'd0;
    state       = 3'd0;
    if (rst) begin
      loadPC = 1'b0;
    end else begin
      mem_timeout = timeout_r;
      instret     = instret_r;
      state       = state_r;
      case (state_r)
        S_EX: begin
          ALUSrc  = src_s;
          ALUCtrl = alu_s;
          case (kind_s)
            K_BEQ: begin loadPC = 1'b1; PCSrc = Zero; end
            K_ILL: begin loadPC = 1'b1; illegal = 1'b1; end
            default: loadPC = 1'b0;
          endcase
        end
        S_MEM: begin
          ALUSrc  = 1'b1;
          ALUCtrl = ALU_ADD;
          if (mem_hit_s) begin
            loadPC = 1'b1;
          end else begin
            MemRead  = (kind_s == K_LW);
            MemWrite = (kind_s == K_SW);
            loadPC   = dmem_ready && (kind_s != K_LW);
          end
        end
        S_WB: begin
          ALUSrc   = src_s;
          ALUCtrl  = alu_s;
          RegWrite = 1'b1;
          loadPC   = 1'b1;
          MemToReg = (kind_s == K_LW);
          MemRead  = (kind_s == K_LW);
        end
        default: loadPC = 1'b0;
      endcase
    end
  end

endmodule
